sm_reg_display_scan: RTL and testbench



---
 rtl/sm_reg_display_scan.sv | 112 +++++++++++
 tb/tb_sm_reg_display_scan.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sm_reg_display_scan.sv
// rtl/sm_reg_display_scan.sv - register-file viewer on active-low 7-segment digits
// Manual or dwell-timed auto-scan of debug registers, paged across DIGITS digits.
module sm_reg_display_scan #(
  parameter int DIGITS = 6,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DWELL  = 50000000,
  localparam int NPAGES = (DATA_W + 4*DIGITS - 1) / (4*DIGITS),
  localparam int PAGE_W = (NPAGES > 1) ? $clog2(NPAGES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [ADDR_W-1:0]     manual_addr,
  input  logic [PAGE_W-1:0]     page_sel,
  input  logic                  blank_lz,
  input  logic                  freeze,
  output logic [ADDR_W-1:0]     reg_addr,
  input  logic [DATA_W-1:0]     reg_data,
  output logic [PAGE_W-1:0]     page,
  output logic [8*DIGITS-1:0]   hex
);

  localparam int CNT_W = $clog2(DWELL);
  localparam int EXT_W = NPAGES * DIGITS * 4;
  localparam int NNIB  = EXT_W / 4;

  logic [CNT_W-1:0]    cnt;
  logic                mode_q;
  logic [DATA_W-1:0]   captured;
  logic [PAGE_W-1:0]   page_d;
  logic                cap_vld;
  logic [PAGE_W-1:0]   page_clamped;
  logic [8*DIGITS-1:0] frame;
  logic [EXT_W-1:0]    ext;
  logic [3:0]          nib;
  logic [6:0]          seg;
  int                  msn;
  int                  n;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  4'hF: seg7 = 7'h0E;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign page_clamped = (int'(page_sel) > NPAGES - 1) ? PAGE_W'(NPAGES - 1) : page_sel;

  // Render from the captured value and the page that selected it one edge earlier.
  always_comb begin
    ext   = '0;
    ext[DATA_W-1:0] = captured;
    msn   = 0;
    nib   = '0;
    seg   = '1;
    n     = 0;
    frame = '1;
    for (int k = 0; k < NNIB; k++) begin
      if (ext[k*4 +: 4] != 4'h0) msn = k;
    end
    for (int i = 0; i < DIGITS; i++) begin
      n   = int'(page_d) * DIGITS + i;
      nib = ext[n*4 +: 4];
      seg = seg7(nib);
      if (blank_lz && n > msn) seg = 7'h7F;
      frame[8*i +: 8] = {!(NPAGES > 1 && i == int'(page_d) % DIGITS), seg};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_addr <= '0;
      page     <= '0;
      cnt      <= '0;
      mode_q   <= 1'b0;
      captured <= '0;
      page_d   <= '0;
      cap_vld  <= 1'b0;
      hex      <= '1;
    end else if (!freeze) begin
      mode_q   <= mode;
      captured <= reg_data;
      page_d   <= page;
      cap_vld  <= 1'b1;
      if (cap_vld) hex <= frame;
      if (!mode) begin
        reg_addr <= manual_addr;
        page     <= page_clamped;
        cnt      <= '0;
      end else if (!mode_q) begin
        // entering auto: restart dwell on page 0 of the current register
        cnt  <= '0;
        page <= '0;
      end else if (cnt == CNT_W'(DWELL - 1)) begin
        cnt <= '0;
        if (int'(page) == NPAGES - 1) begin
          page     <= '0;
          reg_addr <= reg_addr + ADDR_W'(1);
        end else begin
          page <= page + PAGE_W'(1);
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sm_reg_display_scan.sv
// tb/tb_sm_reg_display_scan.sv - scoreboard bench for sm_reg_display_scan
// Reference model derives address/page from elapsed scan time and renders nibbles arithmetically.
module tb_sm_reg_display_scan;

  localparam int DIGITS = 6;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int DWELL  = 4;
  localparam int NPAGES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b0;
  logic [4:0]  manual_addr = '0;
  logic [0:0]  page_sel = '0;
  logic        blank_lz = 1'b0;
  logic        freeze = 1'b0;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;
  logic [0:0]  page;
  logic [47:0] hex;

  logic [31:0] regs [32];
  assign reg_data = regs[reg_addr];

  sm_reg_display_scan #(.DIGITS(DIGITS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DWELL(DWELL)) dut (
    .clk(clk), .rst(rst), .mode(mode), .manual_addr(manual_addr), .page_sel(page_sel),
    .blank_lz(blank_lz), .freeze(freeze), .reg_addr(reg_addr), .reg_data(reg_data),
    .page(page), .hex(hex)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [0:0]  pg;
    logic [47:0] hx;
    int          phase;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   phase = 0;

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // model state
  bit          m_scan;
  int          m_t;
  logic [4:0]  m_start, m_addr;
  int          m_page, m_pd;
  logic [31:0] m_cap;
  bit          m_vld;
  logic [47:0] m_hex;

  function automatic logic [47:0] render(input logic [31:0] v, input int p, input bit blz);
    logic [47:0] r;
    logic [63:0] wide;
    logic [63:0] upper;
    logic [3:0]  nb;
    logic [6:0]  sg;
    int          nn;
    wide = {32'h0, v};
    for (int i = 0; i < DIGITS; i++) begin
      nn    = p * DIGITS + i;
      upper = wide >> (4 * nn);
      nb    = upper[3:0];
      sg    = seg_tbl[nb];
      if (blz && nn != 0 && upper == 64'h0) sg = 7'h7F;
      r[8*i +: 8] = {(i == p % DIGITS) ? 1'b0 : 1'b1, sg};
    end
    return r;
  endfunction

  task automatic model_edge(input bit r, input bit m, input logic [4:0] a,
                            input logic [0:0] ps, input bit bz, input bit fz);
    exp_t e;
    if (r) begin
      m_addr = '0; m_page = 0; m_scan = 0; m_t = 0; m_start = '0;
      m_cap = '0; m_pd = 0; m_vld = 0; m_hex = '1;
    end else if (!fz) begin
      if (m_vld) m_hex = render(m_cap, m_pd, bz);
      m_cap = regs[m_addr];
      m_pd  = m_page;
      m_vld = 1;
      if (!m) begin
        m_scan = 0;
        m_addr = a;
        m_page = (int'(ps) > NPAGES - 1) ? NPAGES - 1 : int'(ps);
      end else if (!m_scan) begin
        m_scan = 1; m_t = 0; m_start = m_addr; m_page = 0;
      end else begin
        m_t++;
        m_page = (m_t / DWELL) % NPAGES;
        m_addr = m_start + 5'((m_t / (DWELL * NPAGES)) % 32);
      end
    end
    e.addr = m_addr; e.pg = 1'(m_page); e.hx = m_hex; e.phase = phase;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit r, input bit m, input logic [4:0] a,
                     input logic [0:0] ps, input bit bz, input bit fz);
    rst = r; mode = m; manual_addr = a; page_sel = ps; blank_lz = bz; freeze = fz;
    @(posedge clk);
    model_edge(r, m, a, ps, bz, fz);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (reg_addr !== e.addr || page !== e.pg || hex !== e.hx) begin
          miscompares++;
          $display("FAIL phase%0d @%0t: got addr=%0d page=%0d hex=%h, expected addr=%0d page=%0d hex=%h",
                   e.phase, $time, reg_addr, page, hex, e.addr, e.pg, e.hx);
        end
      end
    end
  end

  initial begin : stimulus
    bit m, fz, r, bz;
    logic [4:0] a;
    logic [0:0] ps;
    for (int i = 0; i < 32; i++) regs[i] = $urandom >> $urandom_range(0, 31);

    // reset held in auto mode, then first frame of register 0
    phase = 1;
    for (int i = 0; i < 3; i++) cyc(1, 1, 5'd0, 1'b0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 5'd0, 1'b0, 0, 0);

    // manual page 0 / page 1 with and without blanking
    phase = 2;
    regs[5] = 32'h1234ABCD;
    for (int i = 0; i < 4; i++) cyc(0, 0, 5'd5, 1'b0, 0, 0);
    phase = 3;
    for (int i = 0; i < 4; i++) cyc(0, 0, 5'd5, 1'b1, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 5'd5, 1'b1, 0, 0);

    // auto scan from 30 through the address wrap
    phase = 4;
    for (int i = 0; i < 3; i++) cyc(0, 0, 5'd30, 1'b0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 1, 5'd7, 1'b1, 0, 0);

    // freeze mid-dwell, with a mode glitch hidden under it
    phase = 5;
    cyc(0, 1, 5'd7, 1'b0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, (i == 4) ? 1'b0 : 1'b1, 5'd9, 1'b1, 0, 1);
    for (int i = 0; i < 10; i++) cyc(0, 1, 5'd9, 1'b0, 0, 0);

    // zero register with blanking, then reset mid-dwell
    phase = 6;
    regs[0] = 32'h0;
    for (int i = 0; i < 4; i++) cyc(0, 0, 5'd0, 1'b0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 5'd0, 1'b0, 1, 0);
    cyc(1, 1, 5'd0, 1'b0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 5'd0, 1'b0, 1, 0);

    // randomized mix
    phase = 7;
    m = 1; a = '0; ps = '0; bz = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) m = ~m;
      if ($urandom_range(0, 9) == 0) a = 5'($urandom);
      if ($urandom_range(0, 9) == 0) ps = 1'($urandom);
      if ($urandom_range(0, 14) == 0) bz = ~bz;
      fz = ($urandom_range(0, 9) == 0);
      r  = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 7) == 0) regs[$urandom_range(0, 31)] = $urandom >> $urandom_range(0, 31);
      cyc(r, m, a, ps, bz, fz);
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
